// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 FSM states, command bytes and default timing constants.
package ps2_pkg;
  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, DATA, PARITY, STOP, ACK, WAIT_REL} ps2_state_e;
  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] CMD_RESET = 8'hFF;
  localparam logic [7:0] ACK_BYTE = 8'hFA;
  localparam int INHIBIT_CYC_DEF = 6000;
  localparam int TIMEOUT_CYC_DEF = 750000;
  localparam int SYNC_STAGES_DEF = 2;
  function automatic logic odd_par(input logic [7:0] d);
    return ~^d;
  endfunction
endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: synchronises raw PS/2 clock/data lines and flags ps2 clock falling edges.
module ps2_line_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clk_i,
  input  logic dat_i,
  output logic clk_o,
  output logic dat_o,
  output logic fall_o
);
  logic [STAGES-1:0] clk_q, dat_q;
  logic prev_q;
  always_ff @(posedge clk)
    if (!reset_n) begin
      clk_q <= '1;
      dat_q <= '1;
      prev_q <= 1'b1;
    end else begin
      clk_q <= STAGES'({clk_q, clk_i});
      dat_q <= STAGES'({dat_q, dat_i});
      prev_q <= clk_o;
    end
  assign clk_o = clk_q[STAGES-1];
  assign dat_o = dat_q[STAGES-1];
  assign fall_o = prev_q & ~clk_o;
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 byte transmitter with inhibit, request-to-send, parity and ACK check.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYC = INHIBIT_CYC_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);
  localparam int IW = $clog2(INHIBIT_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  ps2_state_e state_q, state_d;
  logic [7:0] sh_q, sh_d;
  logic par_q, par_d, dat_q, dat_d;
  logic [3:0] idx_q, idx_d;
  logic [IW-1:0] inh_q, inh_d;
  logic [TW-1:0] to_q, to_d;
  logic clk_s, dat_s, fall, timeout;
  ps2_line_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .clk_i  (ps2_clk_in),
    .dat_i  (ps2_dat_in),
    .clk_o  (clk_s),
    .dat_o  (dat_s),
    .fall_o (fall)
  );
  // to_q only moves in RTS..WAIT_REL, so it is zero everywhere else
  assign timeout = (to_q == TW'(TIMEOUT_CYC)) & ~fall;
  assign tx_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign ps2_clk_oe = state_q inside {INHIBIT, RTS};
  assign ps2_dat_oe = ~timeout & ((state_q == RTS) | dat_q);
  always_comb begin
    state_d = state_q;
    sh_d = sh_q;
    par_d = par_q;
    dat_d = dat_q;
    idx_d = idx_q;
    tx_done = 1'b0;
    tx_err = 1'b0;
    inh_d = (state_q == INHIBIT && inh_q != IW'(INHIBIT_CYC)) ? inh_q + 1'b1 : inh_q;
    to_d = fall ? '0 : (state_q inside {[RTS:WAIT_REL]} && to_q != TW'(TIMEOUT_CYC)) ? to_q + 1'b1 : to_q;
    if (timeout) begin
      tx_err = 1'b1;
      dat_d = 1'b0;
      state_d = IDLE;
    end else
      case (state_q)
        IDLE: if (tx_valid) begin
          sh_d = tx_data;
          par_d = odd_par(tx_data);
          state_d = INHIBIT;
        end
        INHIBIT: if (inh_q == IW'(INHIBIT_CYC - 1)) state_d = RTS;
        RTS: begin
          dat_d = 1'b1;
          idx_d = '0;
          state_d = DATA;
        end
        DATA: if (fall) begin
          dat_d = ~sh_q[0];
          sh_d = sh_q >> 1;
          idx_d = idx_q + 1'b1;
          state_d = (idx_q == 4'd7) ? PARITY : DATA;
        end
        PARITY: if (fall) begin
          dat_d = ~par_q;
          state_d = STOP;
        end
        STOP: if (fall) begin
          dat_d = 1'b0;
          state_d = ACK;
        end
        ACK: if (fall) begin
          tx_err = dat_s;
          state_d = dat_s ? IDLE : WAIT_REL;
        end
        WAIT_REL: if (clk_s && dat_s) begin
          tx_done = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    if (state_d != state_q) begin
      inh_d = '0;
      to_d = '0;
    end
  end
  always_ff @(posedge clk)
    if (!reset_n) begin
      state_q <= IDLE;
      sh_q <= '0;
      par_q <= 1'b0;
      dat_q <= 1'b0;
      idx_q <= '0;
      inh_q <= '0;
      to_q <= '0;
    end else begin
      state_q <= state_d;
      sh_q <= sh_d;
      par_q <= par_d;
      dat_q <= dat_d;
      idx_q <= idx_d;
      inh_q <= inh_d;
      to_q <= to_d;
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: PS/2 device model plus per-cycle and per-frame checks of ps2_host_tx.
module tb_ps2_host_tx;
  localparam int INH = 20;
  localparam int TO = 500;
  localparam int HALF = 20;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic tx_ready, tx_done, tx_err, busy, ps2_clk_oe, ps2_dat_oe;
  logic ps2_clk_in, ps2_dat_in;
  logic dev_clk = 1'b1;
  logic dev_dat = 1'b1;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  int done_cnt = 0, err_cnt = 0, t_done = 0, t_err = 0, t_acc = 0, t_rts = 0;
  int inh_len = 0, rts_len = 0;
  logic prev_oe = 1'b0;
  logic exp_busy = 1'b0;
  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;
  always #5 clk = ~clk;
  ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TO), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .tx_done   (tx_done),
    .tx_err    (tx_err),
    .busy      (busy),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired (cycle %0d)", nm, cyc);
  endtask
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  // per-cycle model: busy spans accept..pulse, lines released when idle, inhibit/RTS lengths
  always @(negedge clk) begin
    cyc++;
    chk("busy", busy, exp_busy);
    chk("ready", tx_ready, !exp_busy);
    if (!exp_busy) begin
      chk("idle_clk_oe", ps2_clk_oe, 0);
      chk("idle_dat_oe", ps2_dat_oe, 0);
    end
    if (tx_done || tx_err) begin
      chk("pulse_excl", tx_done & tx_err, 0);
      chk("pulse_in_xfer", exp_busy, 1);
    end
    if (tx_done) begin done_cnt++; t_done = cyc; end
    if (tx_err) begin err_cnt++; t_err = cyc; end
    if (reset_n && tx_valid && !exp_busy) t_acc = cyc;
    if (!reset_n) begin
      inh_len = 0;
      rts_len = 0;
    end else if (ps2_clk_oe && !ps2_dat_oe) inh_len++;
    else if (ps2_clk_oe && ps2_dat_oe) begin
      rts_len++;
      t_rts = cyc;
    end else if (prev_oe) begin
      chk("inhibit_len", inh_len, INH);
      chk("rts_len", rts_len, 1);
      inh_len = 0;
      rts_len = 0;
    end
    prev_oe = ps2_clk_oe;
    exp_busy = !reset_n ? 1'b0 : (tx_done || tx_err) ? 1'b0 : (!exp_busy && tx_valid) ? 1'b1 : exp_busy;
  end
  // device: waits for RTS, clocks nfall edges at 40 clk/period, samples on rising edges
  task automatic dev_frame(input int nfall, input bit ack, input bit abort, output logic [10:0] bits);
    int w = 0;
    bits = '0;
    while (!(busy && !ps2_clk_oe && !ps2_dat_in) && w < 500) begin
      step();
      w++;
    end
    if (w >= 500) begin
      fail("rts_wait");
      return;
    end
    repeat (HALF) step();
    bits[0] = ps2_dat_in;
    for (int i = 1; i <= nfall; i++) begin
      if (i == 11 && ack) begin
        dev_dat = 1'b0;
        repeat (5) step();
      end
      dev_clk = 1'b0;
      if (abort && i == nfall) begin
        repeat (5) step();
        return;
      end
      repeat (HALF) step();
      dev_clk = 1'b1;
      dev_dat = 1'b1;
      step();
      if (i <= 10) bits[i] = ps2_dat_in;
      repeat (HALF - 1) step();
    end
  endtask
  task automatic send(input logic [7:0] d, input bit ack, input logic [10:0] lit, input string nm);
    logic [10:0] b;
    int d0 = done_cnt;
    int e0 = err_cnt;
    tx_data = d;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    dev_frame(11, ack, 1'b0, b);
    repeat (5) step();
    chk({nm, "_bits"}, b, {1'b1, ~^d, d, 1'b0});
    chk({nm, "_bits_lit"}, b, lit);
    chk({nm, "_done"}, done_cnt - d0, ack ? 1 : 0);
    chk({nm, "_err"}, err_cnt - e0, ack ? 0 : 1);
    chk({nm, "_busy_after"}, busy, 0);
  endtask
  task automatic timeout_test();
    int e0 = err_cnt;
    int d0 = done_cnt;
    int w = 0;
    tx_data = 8'hF4;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    while (err_cnt == e0 && w < 3000) begin
      step();
      w++;
    end
    chk("to_err", err_cnt - e0, 1);
    chk("to_latency", t_err - t_rts, TO + 1);
    step();
    chk("to_clk_oe", ps2_clk_oe, 0);
    chk("to_dat_oe", ps2_dat_oe, 0);
    chk("to_ready", tx_ready, 1);
    chk("to_no_done", done_cnt - d0, 0);
  endtask
  task automatic reset_test();
    logic [10:0] b;
    int d0 = done_cnt;
    int e0 = err_cnt;
    tx_data = 8'h55;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    dev_frame(5, 1'b0, 1'b1, b);
    chk("rst_partial_bits", b[4:0], 5'b01010);
    reset_n = 1'b0;
    step();
    chk("rst_clk_oe", ps2_clk_oe, 0);
    chk("rst_dat_oe", ps2_dat_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", tx_ready, 1);
    reset_n = 1'b1;
    dev_clk = 1'b1;
    repeat (5) step();
    chk("rst_no_done", done_cnt - d0, 0);
    chk("rst_no_err", err_cnt - e0, 0);
  endtask
  task automatic hold_test();
    logic [10:0] b;
    tx_data = 8'h01;
    tx_valid = 1'b1;
    step();
    tx_data = 8'hF4;
    dev_frame(11, 1'b1, 1'b0, b);
    tx_valid = 1'b0;
    chk("hold_first_bits", b, 11'h402);
    chk("hold_accept_gap", t_acc - t_done, 1);
    chk("hold_second_busy", busy, 1);
    dev_frame(11, 1'b1, 1'b0, b);
    repeat (5) step();
    chk("hold_second_bits", b, 11'h5E8);
    chk("hold_idle_after", tx_ready, 1);
  endtask
  initial begin
    repeat (3) step();
    chk("reset_ready", tx_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_clk_oe", ps2_clk_oe, 0);
    chk("reset_dat_oe", ps2_dat_oe, 0);
    chk("reset_pulses", {tx_done, tx_err}, 2'b00);
    reset_n = 1'b1;
    step();
    send(8'hED, 1'b1, 11'h7DA, "ed");
    send(8'h00, 1'b1, 11'h600, "x00");
    send(8'hFF, 1'b1, 11'h7FE, "xff");
    send(8'h01, 1'b1, 11'h402, "x01");
    timeout_test();
    send(8'hED, 1'b0, 11'h7DA, "nack");
    reset_test();
    send(8'hF4, 1'b1, 11'h5E8, "f4_after_rst");
    hold_test();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #1000000;
    fail("watchdog");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
